// File: rtl/can_frame_tail_checker.sv
// CAN frame tail checker: walks CRC delimiter, ACK slot, ACK delimiter, EOF and
// intermission on sample-point strobes, raising form/ACK/overload/SOF events.
module can_frame_tail_checker #(
    parameter int EOF_LEN = 7,
    parameter int IFS_LEN = 3,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       rx,
    input  logic       tail_start,
    input  logic       tx_mode,
    input  logic       abort,
    output logic       form_err,
    output logic       ack_err,
    output logic       overload_req,
    output logic       frame_ok,
    output logic       sof_det,
    output logic [2:0] err_code,
    output logic       bus_idle
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACK_SLOT = 3'd1,
        S_ACK_DEL  = 3'd2,
        S_EOF      = 3'd3,
        S_IFS      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] EOF_LAST = CNT_W'(EOF_LEN - 1);
    localparam logic [CNT_W-1:0] IFS_LAST = CNT_W'(IFS_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] ERR_CRC_DEL = 3'd1;
    localparam logic [2:0] ERR_ACK_DEL = 3'd2;
    localparam logic [2:0] ERR_EOF     = 3'd3;
    localparam logic [2:0] ERR_ACK     = 3'd4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             form_err_q, form_err_d;
    logic             ack_err_q, ack_err_d;
    logic             overload_req_q, overload_req_d;
    logic             frame_ok_q, frame_ok_d;
    logic             sof_det_q, sof_det_d;
    logic             bus_idle_q, bus_idle_d;

    // Next-state, counter and event decode for one sample-point bit.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_code_d     = err_code_q;
        form_err_d     = 1'b0;
        ack_err_d      = 1'b0;
        overload_req_d = 1'b0;
        frame_ok_d     = 1'b0;
        sof_det_d      = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (sample_en) begin
            // A new tail may only start from a quiet bus or from intermission.
            if (tail_start && (state_q == S_IDLE || state_q == S_IFS)) begin
                cnt_d = CNT_ZERO;
                if (!rx) begin
                    form_err_d = 1'b1;
                    err_code_d = ERR_CRC_DEL;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_ACK_SLOT;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_IDLE;
                    end
                    S_ACK_SLOT: begin
                        cnt_d = CNT_ZERO;
                        if (tx_mode && rx) begin
                            ack_err_d  = 1'b1;
                            err_code_d = ERR_ACK;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_ACK_DEL;
                        end
                    end
                    S_ACK_DEL: begin
                        cnt_d = CNT_ZERO;
                        if (!rx) begin
                            form_err_d = 1'b1;
                            err_code_d = ERR_ACK_DEL;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_EOF;
                        end
                    end
                    S_EOF: begin
                        if (cnt_q == EOF_LAST) begin
                            // Dominant last EOF bit still completes the frame.
                            frame_ok_d = 1'b1;
                            cnt_d      = CNT_ZERO;
                            if (!rx) begin
                                overload_req_d = 1'b1;
                                state_d        = S_IDLE;
                            end else begin
                                state_d = S_IFS;
                            end
                        end else if (!rx) begin
                            form_err_d = 1'b1;
                            err_code_d = ERR_EOF;
                            cnt_d      = CNT_ZERO;
                            state_d    = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    S_IFS: begin
                        if (!rx) begin
                            cnt_d   = CNT_ZERO;
                            state_d = S_IDLE;
                            if (cnt_q == IFS_LAST) begin
                                sof_det_d = 1'b1;
                            end else begin
                                overload_req_d = 1'b1;
                            end
                        end else if (cnt_q == IFS_LAST) begin
                            cnt_d   = CNT_ZERO;
                            state_d = S_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt_d   = CNT_ZERO;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
        bus_idle_d = (state_d == S_IDLE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= CNT_ZERO;
            err_code_q     <= 3'd0;
            form_err_q     <= 1'b0;
            ack_err_q      <= 1'b0;
            overload_req_q <= 1'b0;
            frame_ok_q     <= 1'b0;
            sof_det_q      <= 1'b0;
            bus_idle_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            err_code_q     <= err_code_d;
            form_err_q     <= form_err_d;
            ack_err_q      <= ack_err_d;
            overload_req_q <= overload_req_d;
            frame_ok_q     <= frame_ok_d;
            sof_det_q      <= sof_det_d;
            bus_idle_q     <= bus_idle_d;
        end
    end

    assign form_err     = form_err_q;
    assign ack_err      = ack_err_q;
    assign overload_req = overload_req_q;
    assign frame_ok     = frame_ok_q;
    assign sof_det      = sof_det_q;
    assign err_code     = err_code_q;
    assign bus_idle     = bus_idle_q;

endmodule

// File: doc/can_frame_tail_checker.md
Name: can_frame_tail_checker

Overview:
- Parameterised successor to the single-field EOF checker.
- Checks the whole CAN frame tail, bit by bit on sample-point strobes: CRC delimiter, ACK slot, ACK delimiter, EOF, intermission.
- Flags form, ACK and overload conditions with an error code, and signals frame-complete and bus-idle.
- Sits after the bit de-stuffer / field sequencer in the decoder; its outputs feed the error-frame generator and error counters.

Parameters:
- EOF_LEN, 7, number of EOF bits; legal range 2..15.
- IFS_LEN, 3, number of intermission bits; legal range 2..15.
- CNT_W, 4, width of the internal bit counter; must hold max(EOF_LEN, IFS_LEN)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- sample_en  in  1  one-clk strobe at each bit sample point; all state advances only when high
- rx  in  1  sampled bus level (1 = recessive)
- tail_start  in  1  high with sample_en on the CRC-delimiter bit
- tx_mode  in  1  node is transmitter of current frame; enables ACK-slot check
- abort  in  1  synchronous clear to IDLE, e.g. on an error frame raised elsewhere
- form_err  out  1  one-clk pulse: dominant bit in a fixed-form field
- ack_err  out  1  one-clk pulse: tx_mode=1 and ACK slot recessive
- overload_req  out  1  one-clk pulse: overload condition detected
- frame_ok  out  1  one-clk pulse: EOF completed without error
- sof_det  out  1  one-clk pulse: dominant in the last intermission bit, treated as SOF
- err_code  out  3  last error: 0 none, 1 CRC delimiter, 2 ACK delimiter, 3 EOF, 4 ACK missing; held until next error or reset
- bus_idle  out  1  high whenever state = IDLE

Behaviour:
- Reset (async):
  - state IDLE, counter 0.
  - All pulse outputs 0, err_code 0, bus_idle 1.
  - Reset asserted mid-frame aborts immediately; no pulse is emitted.
- All outputs are registered. Pulses are high for exactly the clk cycle following the sample_en edge that caused them.
- A response appears one clk after the sample_en cycle; no change occurs on cycles where sample_en = 0.
- Priority on each sample_en cycle: abort > tail_start > state logic.
  - abort → IDLE, counter 0, no pulses.
  - tail_start is honoured only in IDLE or IFS; it is ignored in the other states.
- States:
  - IDLE: when tail_start, evaluate the CRC-delimiter bit immediately.
    - rx = 0 → form_err, err_code 1, stay IDLE.
    - rx = 1 → ACK_SLOT.
  - ACK_SLOT: if tx_mode and rx = 1 → ack_err, err_code 4, IDLE. Otherwise → ACK_DEL.
  - ACK_DEL:
    - rx = 0 → form_err, err_code 2, IDLE.
    - rx = 1 → EOF with counter 0.
  - EOF, index = counter:
    - Index < EOF_LEN-1: rx = 0 → form_err, err_code 3, IDLE; otherwise counter+1.
    - Index = EOF_LEN-1: frame_ok always pulses. If rx = 0, overload_req also pulses in the same cycle and the next state is IDLE. Otherwise → IFS with counter 0.
  - IFS, index = counter:
    - rx = 0 and index < IFS_LEN-1 → overload_req, IDLE.
    - rx = 0 and index = IFS_LEN-1 → sof_det, IDLE.
    - rx = 1 at last index → IDLE.
    - Otherwise counter+1.
- The counter never wraps; it is cleared on every state entry.
- err_code is not cleared by frame_ok.

Test Plan:
- tail_start, then rx = 1,1,1, then 7×1, then 3×1, with tx_mode = 0 → frame_ok once after the 7th EOF bit, bus_idle back to 1 after the 3rd IFS bit, no error pulses.
- Same sequence with rx = 0 at EOF bit 4 → form_err, err_code = 3, bus_idle = 1; no frame_ok.
- tx_mode = 1, ACK slot rx = 1 → ack_err, err_code = 4; a later CRC-delimiter rx = 0 → err_code = 1.
- rx = 0 on EOF bit 7 → frame_ok and overload_req in the same cycle. A second frame with rx = 0 on IFS bit 1 → overload_req. A third with rx = 0 on IFS bit 3 → sof_det only.
- reset mid-EOF, and abort coincident with tail_start → IDLE, all pulses 0. For reset, err_code = 0; for abort, err_code unchanged.
- EOF_LEN = 3, IFS_LEN = 2 → frame_ok after the 3rd EOF bit, IDLE after 2 IFS bits; sample_en gaps of 5 clks between bits leave state unchanged.
